// File: rtl/vga_regs_pkg.sv
// Shared definitions for the VGA frame register bank:
// register-select codes, bank size and data widths.
package vga_regs_pkg;

    localparam int REG_W  = 32;
    localparam int TIME_W = 16;
    localparam int NREG   = 11;

    localparam logic [3:0] SEL_B1X        = 4'd0;
    localparam logic [3:0] SEL_B1Y        = 4'd1;
    localparam logic [3:0] SEL_B2X        = 4'd2;
    localparam logic [3:0] SEL_B2Y        = 4'd3;
    localparam logic [3:0] SEL_B3X        = 4'd4;
    localparam logic [3:0] SEL_B3Y        = 4'd5;
    localparam logic [3:0] SEL_B4X        = 4'd6;
    localparam logic [3:0] SEL_B4Y        = 4'd7;
    localparam logic [3:0] SEL_SCORE      = 4'd8;
    localparam logic [3:0] SEL_BLOCKTYPE  = 4'd9;
    localparam logic [3:0] SEL_SCREENMODE = 4'd10;
    localparam logic [3:0] SEL_CLR_TIME   = 4'd11;

endpackage

// File: rtl/vga_sec_timer.sv
// Seconds counter driven by vsync starts: a frame counter wraps every
// FRAMES_PER_SEC frames and bumps sysTime. Ports: iVGA_CLK, iRST_n,
// vs_start, clr (clears both counters, wins over a tick), sysTime.
module vga_sec_timer
    import vga_regs_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              vs_start,
    input  logic              clr,
    output logic [TIME_W-1:0] sysTime
);

    localparam int FW = $clog2(FRAMES_PER_SEC);
    localparam logic [FW-1:0] FLAST = FW'(FRAMES_PER_SEC - 1);

    logic [FW-1:0]     fcnt;
    logic [TIME_W-1:0] sec_q;

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n || clr) begin
            fcnt  <= '0;
            sec_q <= '0;
        end else if (vs_start) begin
            if (fcnt == FLAST) begin
                fcnt  <= '0;
                sec_q <= sec_q + 1'b1;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    assign sysTime = sec_q;

endmodule

// File: rtl/vga_frame_regs.sv
// Frame-synchronous shadow/live register bank feeding the VGA controller.
// Ports: iVGA_CLK, iRST_n, iVS (active-low vsync), wr_en/wr_sel/wr_data
// shadow writes, commit; live outputs block1x..block4y, score, blockType,
// screenMode, sysTime, commit_pending, frame_swap.
// Optional macro VGA_FRAME_REGS_READBACK_EN adds rd_sel/rd_data.
module vga_frame_regs
    import vga_regs_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iVS,
    input  logic              wr_en,
    input  logic [3:0]        wr_sel,
    input  logic [REG_W-1:0]  wr_data,
    input  logic              commit,
`ifdef VGA_FRAME_REGS_READBACK_EN
    input  logic [3:0]        rd_sel,
    output logic [REG_W-1:0]  rd_data,
`endif
    output logic [REG_W-1:0]  block1x,
    output logic [REG_W-1:0]  block1y,
    output logic [REG_W-1:0]  block2x,
    output logic [REG_W-1:0]  block2y,
    output logic [REG_W-1:0]  block3x,
    output logic [REG_W-1:0]  block3y,
    output logic [REG_W-1:0]  block4x,
    output logic [REG_W-1:0]  block4y,
    output logic [REG_W-1:0]  score,
    output logic [REG_W-1:0]  blockType,
    output logic [REG_W-1:0]  screenMode,
    output logic [TIME_W-1:0] sysTime,
    output logic              commit_pending,
    output logic              frame_swap
);

    logic             vs_prev;
    logic             vs_start;
    logic             do_swap;
    logic             clr_time;
    logic             wr_shadow;
    logic [REG_W-1:0] shadow [NREG];
    logic [REG_W-1:0] live   [NREG];

    assign vs_start  = vs_prev & ~iVS;
    assign do_swap   = vs_start & commit_pending;
    assign clr_time  = wr_en && (wr_sel == SEL_CLR_TIME);
    assign wr_shadow = wr_en && (wr_sel <= SEL_SCREENMODE);

    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            vs_prev        <= 1'b1;
            commit_pending <= 1'b0;
            frame_swap     <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                shadow[i] <= '0;
                live[i]   <= '0;
            end
        end else begin
            vs_prev    <= iVS;
            frame_swap <= do_swap;
            // Live copy reads the old shadow, so a same-cycle write
            // lands only in the shadow.
            if (do_swap) begin
                for (int i = 0; i < NREG; i++)
                    live[i] <= shadow[i];
            end
            if (wr_shadow)
                shadow[wr_sel] <= wr_data;
            // A fresh commit outranks the clear from a swap.
            if (commit)
                commit_pending <= 1'b1;
            else if (do_swap)
                commit_pending <= 1'b0;
        end
    end

    assign block1x    = live[SEL_B1X];
    assign block1y    = live[SEL_B1Y];
    assign block2x    = live[SEL_B2X];
    assign block2y    = live[SEL_B2Y];
    assign block3x    = live[SEL_B3X];
    assign block3y    = live[SEL_B3Y];
    assign block4x    = live[SEL_B4X];
    assign block4y    = live[SEL_B4Y];
    assign score      = live[SEL_SCORE];
    assign blockType  = live[SEL_BLOCKTYPE];
    assign screenMode = live[SEL_SCREENMODE];

    vga_sec_timer #(
        .FRAMES_PER_SEC(FRAMES_PER_SEC)
    ) u_timer (
        .iVGA_CLK(iVGA_CLK),
        .iRST_n  (iRST_n),
        .vs_start(vs_start),
        .clr     (clr_time),
        .sysTime (sysTime)
    );

`ifdef VGA_FRAME_REGS_READBACK_EN
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n)
            rd_data <= '0;
        else if (rd_sel <= SEL_SCREENMODE)
            rd_data <= shadow[rd_sel];
        else if (rd_sel == SEL_CLR_TIME)
            rd_data <= {{(REG_W-TIME_W){1'b0}}, sysTime};
        else
            rd_data <= '0;
    end
`endif

endmodule

// File: tb/tb_vga_frame_regs.sv
// Directed bench for vga_frame_regs: vector table for the bank and
// commit behaviour, hand sequences for the seconds timer and reset.
module tb_vga_frame_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ivs;
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic [31:0] wr_data;
    logic        commit;
    logic [31:0] b1x, b1y, b2x, b2y, b3x, b3y, b4x, b4y;
    logic [31:0] score, btype, smode;
    logic [15:0] systime;
    logic        pend, swap;
`ifdef VGA_FRAME_REGS_READBACK_EN
    logic [3:0]  rd_sel;
    logic [31:0] rd_data;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_frame_regs #(.FRAMES_PER_SEC(4)) dut (
        .iVGA_CLK      (clk),
        .iRST_n        (rst_n),
        .iVS           (ivs),
        .wr_en         (wr_en),
        .wr_sel        (wr_sel),
        .wr_data       (wr_data),
        .commit        (commit),
`ifdef VGA_FRAME_REGS_READBACK_EN
        .rd_sel        (rd_sel),
        .rd_data       (rd_data),
`endif
        .block1x       (b1x),
        .block1y       (b1y),
        .block2x       (b2x),
        .block2y       (b2y),
        .block3x       (b3x),
        .block3y       (b3y),
        .block4x       (b4x),
        .block4y       (b4y),
        .score         (score),
        .blockType     (btype),
        .screenMode    (smode),
        .sysTime       (systime),
        .commit_pending(pend),
        .frame_swap    (swap)
    );

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] data;
        logic        cm;
        logic        vs;
        logic        e_pend;
        logic        e_swap;
        logic [31:0] e_b1x;
        logic [31:0] e_b1y;
        logic [31:0] e_score;
        logic [31:0] e_mode;
    } vec_t;

    vec_t vt [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wr_en   = 1'b0;
        wr_sel  = 4'd0;
        wr_data = 32'd0;
        commit  = 1'b0;
    endtask

    task automatic vsync();
        idle_in();
        ivs = 1'b0;
        step();
        ivs = 1'b1;
        step();
    endtask

    function automatic vec_t mk(logic we, logic [3:0] sel, logic [31:0] d,
                                logic cm, logic vs, logic ep, logic es,
                                logic [31:0] ex, logic [31:0] ey,
                                logic [31:0] esc, logic [31:0] em);
        vec_t v;
        v.we = we; v.sel = sel; v.data = d; v.cm = cm; v.vs = vs;
        v.e_pend = ep; v.e_swap = es; v.e_b1x = ex; v.e_b1y = ey;
        v.e_score = esc; v.e_mode = em;
        return v;
    endfunction

    localparam logic [31:0] M = 32'h2000_0000;

    initial begin
        // we sel data cm vs | pend swap b1x b1y score mode
        vt.push_back(mk(1,10,M,   0,1, 0,0, 0,0,0,   0));
        vt.push_back(mk(1, 8,1234,0,1, 0,0, 0,0,0,   0));
        vt.push_back(mk(0, 0,0,   1,1, 1,0, 0,0,0,   0));
        vt.push_back(mk(0, 0,0,   0,1, 1,0, 0,0,0,   0));
        vt.push_back(mk(0, 0,0,   0,0, 0,1, 0,0,1234,M));
        vt.push_back(mk(0, 0,0,   0,0, 0,0, 0,0,1234,M));
        vt.push_back(mk(0, 0,0,   0,1, 0,0, 0,0,1234,M));
        vt.push_back(mk(1, 0,5,   0,1, 0,0, 0,0,1234,M));
        for (int i = 0; i < 3; i++) begin
            vt.push_back(mk(0,0,0,0,0, 0,0, 0,0,1234,M));
            vt.push_back(mk(0,0,0,0,1, 0,0, 0,0,1234,M));
        end
        vt.push_back(mk(0, 0,0,   1,1, 1,0, 0,0,1234,M));
        vt.push_back(mk(0, 0,0,   0,0, 0,1, 5,0,1234,M));
        vt.push_back(mk(0, 0,0,   0,1, 0,0, 5,0,1234,M));
        vt.push_back(mk(1, 1,7,   1,0, 1,0, 5,0,1234,M));
        vt.push_back(mk(0, 0,0,   0,1, 1,0, 5,0,1234,M));
        vt.push_back(mk(0, 0,0,   0,0, 0,1, 5,7,1234,M));
        vt.push_back(mk(0, 0,0,   0,1, 0,0, 5,7,1234,M));
        vt.push_back(mk(0, 0,0,   1,1, 1,0, 5,7,1234,M));
        vt.push_back(mk(1, 8,99,  0,0, 0,1, 5,7,1234,M));
        vt.push_back(mk(0, 0,0,   0,1, 0,0, 5,7,1234,M));
        vt.push_back(mk(0, 0,0,   1,1, 1,0, 5,7,1234,M));
        vt.push_back(mk(0, 0,0,   0,0, 0,1, 5,7,99,  M));
        vt.push_back(mk(0, 0,0,   0,1, 0,0, 5,7,99,  M));
        vt.push_back(mk(0, 0,0,   1,1, 1,0, 5,7,99,  M));
        vt.push_back(mk(0, 0,0,   1,0, 1,1, 5,7,99,  M));
        vt.push_back(mk(0, 0,0,   0,1, 1,0, 5,7,99,  M));

        idle_in();
        ivs   = 1'b1;
        rst_n = 1'b0;
`ifdef VGA_FRAME_REGS_READBACK_EN
        rd_sel = 4'd0;
`endif
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ivs = i[0];
            step();
            check("idle_pend", {31'd0, pend}, 0);
            check("idle_swap", {31'd0, swap}, 0);
            check("idle_mode", smode, 0);
            check("idle_score", score, 0);
            check("idle_b4y", b4y, 0);
        end
        ivs = 1'b1;
        step();

        foreach (vt[i]) begin
            wr_en   = vt[i].we;
            wr_sel  = vt[i].sel;
            wr_data = vt[i].data;
            commit  = vt[i].cm;
            ivs     = vt[i].vs;
            step();
            check($sformatf("v%0d_pend", i), {31'd0, pend},
                  {31'd0, vt[i].e_pend});
            check($sformatf("v%0d_swap", i), {31'd0, swap},
                  {31'd0, vt[i].e_swap});
            check($sformatf("v%0d_b1x", i), b1x, vt[i].e_b1x);
            check($sformatf("v%0d_b1y", i), b1y, vt[i].e_b1y);
            check($sformatf("v%0d_score", i), score, vt[i].e_score);
            check($sformatf("v%0d_mode", i), smode, vt[i].e_mode);
        end
        idle_in();
        ivs = 1'b1;

`ifdef VGA_FRAME_REGS_READBACK_EN
        rd_sel = 4'd0;
        step();
        check("rd_sel0", rd_data, 5);
        rd_sel = 4'd13;
        step();
        check("rd_sel13", rd_data, 0);
`endif

        // Pending commit from the last vector swaps once more here.
        vsync();
        check("tail_pend", {31'd0, pend}, 0);

        // Seconds timer, 4 frames per second.
        wr_en  = 1'b1;
        wr_sel = 4'd11;
        step();
        idle_in();
        check("clr0", {16'd0, systime}, 0);
        for (int i = 0; i < 8; i++) vsync();
        check("sec_8vs", {16'd0, systime}, 2);
        for (int i = 0; i < 3; i++) vsync();
        check("sec_11vs", {16'd0, systime}, 2);
        ivs    = 1'b0;
        wr_en  = 1'b1;
        wr_sel = 4'd11;
        step();
        idle_in();
        check("clr_wins", {16'd0, systime}, 0);
        ivs = 1'b1;
        step();
        for (int i = 0; i < 3; i++) vsync();
        check("fcnt0_3vs", {16'd0, systime}, 0);
        vsync();
        check("fcnt0_4vs", {16'd0, systime}, 1);

        force dut.u_timer.sec_q = 16'hFFFF;
        #1;
        release dut.u_timer.sec_q;
        step();
        check("preload", {16'd0, systime}, 32'h0000_FFFF);
        for (int i = 0; i < 3; i++) vsync();
        check("pre_3vs", {16'd0, systime}, 32'h0000_FFFF);
        vsync();
        check("wrap", {16'd0, systime}, 0);

        // Reset while a commit is pending.
        wr_en   = 1'b1;
        wr_sel  = 4'd2;
        wr_data = 32'd42;
        commit  = 1'b1;
        step();
        idle_in();
        check("rst_pre_pend", {31'd0, pend}, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_pend", {31'd0, pend}, 0);
        check("rst_swap", {31'd0, swap}, 0);
        check("rst_b1x", b1x, 0);
        check("rst_b1y", b1y, 0);
        check("rst_score", score, 0);
        check("rst_mode", smode, 0);
        check("rst_time", {16'd0, systime}, 0);
        ivs = 1'b0;
        step();
        check("rst_vs_swap", {31'd0, swap}, 0);
        check("rst_vs_b2x", b2x, 0);
        ivs = 1'b1;
        step();
        check("rst_vs_b2x2", b2x, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
